// File: rtl/reg_file_mp.sv
// Multi-port register file with write-through bypass and a pending-write scoreboard.
// Reads are combinational (0 cycles); no backpressure, decode stalls on read_busy instead.
module reg_file_mp #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   read_reg_num,
    output logic [NRD*XLEN-1:0] read_data,
    output logic [NRD-1:0]      read_busy,
    input  logic [NWR-1:0]      regwrite,
    input  logic [NWR*AW-1:0]   write_reg,
    input  logic [NWR*XLEN-1:0] write_data,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_reg
);

    generate
        if (NREGS < 4 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
            $error("reg_file_mp: NREGS must be a power of 2 and at least 4");
        end
        if (NRD < 1 || NRD > 4) begin : g_bad_nrd
            $error("reg_file_mp: NRD must be in 1..4");
        end
        if (NWR < 1 || NWR > 2) begin : g_bad_nwr
            $error("reg_file_mp: NWR must be in 1..2");
        end
    endgenerate

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    // Clears first, then the issue set, so a new producer outranks a retiring one.
    always_comb begin
        busy_nxt = busy;
        for (int w = 0; w < NWR; w++) begin
            if (regwrite[w]) begin
                busy_nxt[write_reg[w*AW +: AW]] = 1'b0;
            end
        end
        if (issue_valid && issue_reg != '0) begin
            busy_nxt[issue_reg] = 1'b1;
        end
    end

    // Ascending port order makes the highest-index port win a collision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= XLEN'(i);
            end
            busy <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (regwrite[w] && write_reg[w*AW +: AW] != '0) begin
                    regs[write_reg[w*AW +: AW]] <= write_data[w*XLEN +: XLEN];
                end
            end
            busy <= busy_nxt;
        end
    end

    always_comb begin : read_mux
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        logic            hit;
        read_data = '0;
        read_busy = '0;
        ra        = '0;
        rd        = '0;
        hit       = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            ra  = read_reg_num[p*AW +: AW];
            rd  = regs[ra];
            hit = 1'b0;
            for (int w = 0; w < NWR; w++) begin
                if (!reset && regwrite[w] && write_reg[w*AW +: AW] == ra) begin
                    rd  = write_data[w*XLEN +: XLEN];
                    hit = 1'b1;
                end
            end
            if (ra == '0) begin
                rd = '0;
            end
            read_data[p*XLEN +: XLEN] = rd;
            read_busy[p] = !reset && busy[ra] && !hit && (ra != '0);
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed vector table, reset corner sequence, then random traffic vs a model.
module tb_reg_file_mp;
    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic                clock = 1'b0;
    logic                reset;
    logic [NRD*AW-1:0]   read_reg_num;
    logic [NRD*XLEN-1:0] read_data;
    logic [NRD-1:0]      read_busy;
    logic [NWR-1:0]      regwrite;
    logic [NWR*AW-1:0]   write_reg;
    logic [NWR*XLEN-1:0] write_data;
    logic                issue_valid;
    logic [AW-1:0]       issue_reg;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clock       (clock),
        .reset       (reset),
        .read_reg_num(read_reg_num),
        .read_data   (read_data),
        .read_busy   (read_busy),
        .regwrite    (regwrite),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_busy [NREGS];

    typedef struct {
        logic [AW-1:0]   rd0, rd1;
        logic [1:0]      we;
        logic [AW-1:0]   wr0, wr1;
        logic [XLEN-1:0] wd0, wd1;
        logic            iv;
        logic [AW-1:0]   ir;
        logic [XLEN-1:0] ed0, ed1;
        logic            eb0, eb1;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input int rd0, input int rd1, input int we,
                                input int wr0, input logic [XLEN-1:0] wd0,
                                input int wr1, input logic [XLEN-1:0] wd1,
                                input int iv, input int ir,
                                input logic [XLEN-1:0] ed0, input logic [XLEN-1:0] ed1,
                                input int eb0, input int eb1);
        vec_t v;
        v.rd0 = AW'(rd0); v.rd1 = AW'(rd1); v.we = 2'(we);
        v.wr0 = AW'(wr0); v.wd0 = wd0; v.wr1 = AW'(wr1); v.wd1 = wd1;
        v.iv  = 1'(iv);   v.ir  = AW'(ir);
        v.ed0 = ed0; v.ed1 = ed1; v.eb0 = 1'(eb0); v.eb1 = 1'(eb1);
        return v;
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = XLEN'(i);
            m_busy[i] = 1'b0;
        end
    endtask

    // Effect of one clock edge under the current inputs.
    task automatic model_edge();
        int a;
        if (reset) return;
        for (int w = 0; w < NWR; w++) begin
            a = int'(write_reg[w*AW +: AW]);
            if (regwrite[w] && a != 0) begin
                m_regs[a] = write_data[w*XLEN +: XLEN];
                m_busy[a] = 1'b0;
            end
        end
        if (issue_valid && issue_reg != 0) m_busy[int'(issue_reg)] = 1'b1;
    endtask

    function automatic logic [XLEN-1:0] exp_data(input int a);
        if (a == 0) return '0;
        if (!reset) begin
            for (int w = NWR - 1; w >= 0; w--) begin
                if (regwrite[w] && int'(write_reg[w*AW +: AW]) == a) return write_data[w*XLEN +: XLEN];
            end
        end
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (reset || a == 0) return 1'b0;
        for (int w = 0; w < NWR; w++) begin
            if (regwrite[w] && int'(write_reg[w*AW +: AW]) == a) return 1'b0;
        end
        return m_busy[a];
    endfunction

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic drive(input int rd0, input int rd1, input int we,
                         input int wr0, input logic [XLEN-1:0] wd0,
                         input int wr1, input logic [XLEN-1:0] wd1,
                         input int iv, input int ir);
        read_reg_num = {AW'(rd1), AW'(rd0)};
        regwrite     = 2'(we);
        write_reg    = {AW'(wr1), AW'(wr0)};
        write_data   = {wd1, wd0};
        issue_valid  = 1'(iv);
        issue_reg    = AW'(ir);
    endtask

    task automatic check_model(input string tag);
        int a;
        for (int p = 0; p < NRD; p++) begin
            a = int'(read_reg_num[p*AW +: AW]);
            chk($sformatf("%s p%0d data", tag, p), read_data[p*XLEN +: XLEN], exp_data(a));
            chk($sformatf("%s p%0d busy", tag, p), XLEN'(read_busy[p]), XLEN'(exp_busy(a)));
        end
    endtask

    localparam logic [XLEN-1:0] ONES = '1;

    initial begin
        vecs[0]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[1]  = mk(5, 31, 0, 0, 0, 0, 0, 0, 0, 5, 31, 0, 0);
        vecs[2]  = mk(0, 0, 1, 0, 999, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 5, 1, 5, 100, 0, 0, 0, 0, 0, 100, 0, 0);
        vecs[4]  = mk(5, 29, 2, 0, 0, 29, ONES, 0, 0, 100, ONES, 0, 0);
        vecs[5]  = mk(29, 8, 3, 8, 11, 8, 22, 0, 0, ONES, 22, 0, 0);
        vecs[6]  = mk(8, 9, 3, 9, 33, 10, 44, 0, 0, 22, 33, 0, 0);
        vecs[7]  = mk(9, 10, 0, 0, 0, 0, 0, 0, 0, 33, 44, 0, 0);
        vecs[8]  = mk(12, 12, 0, 0, 0, 0, 0, 1, 12, 12, 12, 0, 0);
        vecs[9]  = mk(12, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 1, 0);
        vecs[10] = mk(12, 12, 1, 12, 144, 0, 0, 0, 0, 144, 144, 0, 0);
        vecs[11] = mk(12, 3, 0, 0, 0, 0, 0, 0, 0, 144, 3, 0, 0);
        vecs[12] = mk(12, 12, 2, 0, 0, 12, 55, 1, 12, 55, 55, 0, 0);
        vecs[13] = mk(12, 15, 0, 15, 777, 0, 0, 0, 0, 55, 15, 1, 0);
        vecs[14] = mk(15, 12, 0, 15, 777, 0, 0, 0, 0, 15, 55, 0, 1);
        vecs[15] = mk(15, 15, 0, 0, 0, 0, 0, 0, 0, 15, 15, 0, 0);

        reset = 1'b1;
        drive(1, 31, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        tick();
        tick();
        chk("reset rd1", read_data[0 +: XLEN], 1);
        chk("reset rd31", read_data[XLEN +: XLEN], 31);
        chk("reset busy", XLEN'(read_busy), 0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rd0, vecs[i].rd1, vecs[i].we, vecs[i].wr0, vecs[i].wd0,
                  vecs[i].wr1, vecs[i].wd1, vecs[i].iv, vecs[i].ir);
            #1;
            chk($sformatf("vec%0d d0", i), read_data[0 +: XLEN], vecs[i].ed0);
            chk($sformatf("vec%0d d1", i), read_data[XLEN +: XLEN], vecs[i].ed1);
            chk($sformatf("vec%0d b0", i), XLEN'(read_busy[0]), XLEN'(vecs[i].eb0));
            chk($sformatf("vec%0d b1", i), XLEN'(read_busy[1]), XLEN'(vecs[i].eb1));
            tick();
        end

        // Reset landing between edges while reg 3 and reg 12 hold pending state.
        drive(3, 12, 1, 3, 48, 0, 0, 1, 3);
        #1;
        chk("rst seq bypass 48", read_data[0 +: XLEN], 48);
        chk("rst seq busy12", XLEN'(read_busy[1]), 1);
        tick();
        drive(3, 12, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst seq reg3 48", read_data[0 +: XLEN], 48);
        chk("rst seq busy3", XLEN'(read_busy), 3);
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst seq reg3 reset", read_data[0 +: XLEN], 3);
        chk("rst seq reg12 reset", read_data[XLEN +: XLEN], 12);
        chk("rst seq busy cleared", XLEN'(read_busy), 0);
        drive(3, 12, 2, 0, 0, 3, 77, 1, 12);
        #1;
        chk("rst seq no bypass", read_data[0 +: XLEN], 3);
        tick();
        chk("rst seq edge no write", read_data[0 +: XLEN], 3);
        chk("rst seq edge no issue", XLEN'(read_busy), 0);
        reset = 1'b0;
        issue_valid = 1'b0;
        #1;
        chk("rst seq bypass after", read_data[0 +: XLEN], 77);
        tick();
        regwrite = '0;
        #1;
        chk("rst seq written 77", read_data[0 +: XLEN], 77);
        chk("rst seq reg12 idle", read_data[XLEN +: XLEN], 12);

        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 39) == 0);
            if (reset) model_reset();
            drive(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7),
                  $urandom_range(0, 7),
                  $urandom_range(0, 3),
                  $urandom_range(0, 7), {$urandom, $urandom},
                  $urandom_range(0, 7), {$urandom, $urandom},
                  $urandom_range(0, 1), $urandom_range(0, 7));
            #1;
            check_model($sformatf("rand%0d", c));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
